// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: idle-detecting clock gate controller with 4-phase sleep handshake
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W = $clog2(IDLE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic busy_i,
  input  logic wake_i,
  input  logic sleep_ack_i,
  output logic sleep_req_o,
  output logic en_o,
  output logic gated_o
);
  typedef enum logic [1:0] {RUN, DRAIN, GATED, WAKE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic idle, at_max;
  assign idle = enable_i & ~busy_i & ~wake_i;
  assign at_max = cnt == CNT_W'(IDLE_CYCLES - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = RUN;
    cnt_nxt = '0;
    case (state)
      RUN: begin
        state_nxt = idle && at_max ? DRAIN : RUN;
        cnt_nxt = idle && !at_max ? cnt + 1'b1 : '0;
      end
      DRAIN: state_nxt = !idle ? WAKE : sleep_ack_i ? GATED : DRAIN;
      GATED: state_nxt = idle ? GATED : WAKE;
      WAKE: state_nxt = sleep_ack_i ? WAKE : RUN;
      default: state_nxt = RUN;
    endcase
  end
  assign en_o = state != GATED;
  assign sleep_req_o = state == DRAIN || state == GATED;
  assign gated_o = state == GATED;
endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 Parameter IDLE_CYCLES, default 16, consecutive idle cycles before gating is requested; legal range 1..65535.
REQ-002 Parameter CNT_W, default $clog2(IDLE_CYCLES+1), idle counter width; derived, not overridden.
REQ-003 clk_i  input  1  free-running clock; all logic on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 enable_i  input  1  gating permitted; 0 forbids entering or staying gated.
REQ-006 busy_i  input  1  activity indication from the gated block, sourced from ungated logic.
REQ-007 wake_i  input  1  external wake request; level sensitive.
REQ-008 sleep_ack_i  input  1  block acknowledges quiescence; 4-phase with sleep_req_o.
REQ-009 sleep_req_o  output  1  request to the block to quiesce.
REQ-010 en_o  output  1  enable to the clock gate cell's en_i; 1 = clock running.
REQ-011 gated_o  output  1  status, 1 while clock is gated.

Function
REQ-012 An idle cycle SHALL be a cycle with enable_i=1, busy_i=0, wake_i=0.
REQ-013 FSM states SHALL be RUN, DRAIN, GATED, WAKE.
REQ-014 Outputs SHALL decode from the state register only: en_o=0 only in GATED; sleep_req_o=1 in DRAIN and GATED; gated_o=1 only in GATED; no combinational input-to-output path.
REQ-015 RUN: idle counter SHALL increment on each idle cycle and clear to 0 on any non-idle cycle.
REQ-016 RUN: an idle cycle with counter = IDLE_CYCLES-1 SHALL move to DRAIN next cycle and clear the counter; sleep_req_o thus rises on the cycle after the IDLE_CYCLES-th consecutive idle cycle.
REQ-017 DRAIN: any non-idle cycle SHALL move to WAKE (abort), taking priority over sleep_ack_i.
REQ-018 DRAIN: idle cycle with sleep_ack_i=1 SHALL move to GATED; otherwise remain in DRAIN indefinitely.
REQ-019 GATED: any non-idle cycle (busy_i, wake_i, or enable_i=0) SHALL move to WAKE; en_o returns to 1 exactly one cycle after the triggering input is sampled.
REQ-020 WAKE: sleep_req_o=0, en_o=1; SHALL remain until sleep_ack_i=0, then move to RUN with counter 0, regardless of busy_i/wake_i.
REQ-021 No direct RUN->GATED, DRAIN->RUN, or GATED->RUN transition SHALL exist.
REQ-022 sleep_req_o SHALL NOT deassert before sleep_ack_i has been observed at 1 or the request is aborted via WAKE; WAKE SHALL always wait for sleep_ack_i=0 before a new request.
REQ-023 Counter SHALL never exceed IDLE_CYCLES-1 and SHALL not wrap.
REQ-024 IDLE_CYCLES=1 SHALL move RUN->DRAIN after a single idle cycle.
REQ-025 Unreachable state encodings SHALL recover to RUN next cycle.

Reset
REQ-026 rst_i=1 at a clock edge SHALL force RUN, counter 0, en_o=1, sleep_req_o=0, gated_o=0 from the next cycle, from any state including GATED and DRAIN.
REQ-027 Reset SHALL take priority over all inputs; outputs hold reset values while rst_i=1.

Verification
REQ-028 IDLE_CYCLES=4, busy_i=0, sleep_ack_i follows sleep_req_o by 2 cycles -> sleep_req_o rises after 4th idle cycle, en_o=0 and gated_o=1 one cycle after ack sampled.
REQ-029 Idle run of 3 cycles, busy_i pulse, then 4 idle -> no sleep_req_o until 4 consecutive idle cycles after the pulse.
REQ-030 In DRAIN with sleep_ack_i=1 and busy_i=1 same cycle -> WAKE, en_o stays 1, sleep_req_o drops next cycle; RUN only after ack deasserts.
REQ-031 In GATED, wake_i pulse for 1 cycle -> en_o=1 next cycle, gated_o=0, WAKE held while sleep_ack_i=1, RUN when ack falls, counter restarts at 0.
REQ-032 enable_i=0 held 100 cycles with busy_i=0 -> sleep_req_o and gated_o never assert; enable_i=0 in GATED -> WAKE next cycle.
REQ-033 rst_i=1 for one cycle while GATED -> en_o=1, sleep_req_o=0, gated_o=0 next cycle; IDLE_CYCLES=1 then gates after single idle cycle plus handshake.
